// File: rtl/packer_pkg.sv
// Shared constants, counter type and slot-placement helper for the byte packer.
package packer_pkg;

    localparam int unsigned BYTE_W = 8;

    // Wide enough for a byte count of up to 8 (BYTES is limited to 2..8).
    typedef logic [3:0] cnt_t;

    // Bit position of the least significant bit of byte slot k within the word.
    function automatic int unsigned slot_lsb(input int unsigned k,
                                             input int unsigned bytes,
                                             input bit          msb_first);
        if (msb_first) begin
            return BYTE_W * (bytes - 1 - k);
        end
        return BYTE_W * k;
    endfunction

endpackage

// File: rtl/pack_out_stage.sv
// One-entry valid/ready holding register for an assembled word and its byte count.
module pack_out_stage
    import packer_pkg::*;
#(
    parameter int unsigned DATA_W = BYTE_W * 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_bytes,
    input  logic              out_ready,
    output logic              out_free,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_bytes
);

    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  bytes_q;
    logic              valid_q;

    // Slot is free when empty or being drained this cycle; a load then replaces it.
    assign out_free  = ~valid_q | out_ready;
    assign out_data  = data_q;
    assign out_bytes = bytes_q;
    assign out_valid = valid_q;

    // Load a new word when free, otherwise hold; drain clears valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            bytes_q <= '0;
            valid_q <= 1'b0;
        end else if (load && out_free) begin
            data_q  <= load_data;
            bytes_q <= load_bytes;
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_packer.sv
// Packs a valid/ready byte stream into BYTES-wide words, with flush for partial words.
module byte_packer
    import packer_pkg::*;
#(
    parameter int unsigned BYTES     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [BYTE_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [BYTE_W*BYTES-1:0]      out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(BYTES+1)-1:0]   out_bytes
);

    localparam int unsigned DATA_W = BYTE_W * BYTES;
    localparam int unsigned OB_W   = $clog2(BYTES + 1);
    localparam cnt_t        LAST   = cnt_t'(BYTES - 1);

    cnt_t              cnt_q, cnt_d;
    cnt_t              fill;
    logic [DATA_W-1:0] acc_q, acc_d, merged;
    logic              out_free;
    logic              byte_fire, flush_fire, complete, load;
    logic [OB_W-1:0]   load_bytes;

    // A byte that would complete a word needs the output slot; a pending flush
    // blocks bytes until it can be taken together with them.
    assign in_ready   = out_free | ((cnt_q != LAST) & ~flush);
    assign byte_fire  = in_valid & in_ready;
    assign flush_fire = flush & out_free & ((cnt_q != '0) | in_valid);
    assign complete   = byte_fire & (cnt_q == LAST);
    assign load       = complete | flush_fire;
    assign fill       = cnt_q + cnt_t'(byte_fire);
    assign load_bytes = complete ? OB_W'(BYTES) : OB_W'(fill);

    // Accumulator with this cycle's byte dropped into slot cnt.
    always_comb begin
        merged = acc_q;
        for (int unsigned k = 0; k < BYTES; k++) begin
            if (byte_fire && (cnt_q == cnt_t'(k))) begin
                merged[slot_lsb(k, BYTES, MSB_FIRST) +: BYTE_W] = in_data;
            end
        end
    end

    // Next accumulator/counter: restart on emit, advance on accepted byte.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (byte_fire) begin
            acc_d = merged;
            cnt_d = fill;
        end
    end

    // Accumulator and counter registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    pack_out_stage #(
        .DATA_W (DATA_W),
        .CNT_W  (OB_W)
    ) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (merged),
        .load_bytes (load_bytes),
        .out_ready  (out_ready),
        .out_free   (out_free),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_bytes  (out_bytes)
    );

endmodule

// File: tb/tb_byte_packer.sv
// Directed bench for byte_packer: MSB-first and LSB-first instances.
module tb_byte_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_bytes;

    logic [7:0]  l_in_data = '0;
    logic        l_in_valid = 1'b0;
    logic        l_in_ready;
    logic [31:0] l_out_data;
    logic        l_out_valid;
    logic [2:0]  l_out_bytes;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    byte_packer #(.BYTES(4), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bytes (out_bytes)
    );

    byte_packer #(.BYTES(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (l_in_data),
        .in_valid  (l_in_valid),
        .in_ready  (l_in_ready),
        .flush     (1'b0),
        .out_data  (l_out_data),
        .out_valid (l_out_valid),
        .out_ready (1'b1),
        .out_bytes (l_out_bytes)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [31:0] d, input logic [2:0] n);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".data"}, 64'(out_data), 64'(d));
        check({tag, ".bytes"}, 64'(out_bytes), 64'(n));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.data", 64'(out_data), 64'd0);
        check("rst.bytes", 64'(out_bytes), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Basic MSB-first word, latency one cycle after the fourth byte
        send(8'h00);
        send(8'h00);
        send(8'h00);
        check("basic.pre_valid", 64'(out_valid), 64'd0);
        send(8'h05);
        check_word("basic", 32'h0000_0005, 3'd4);
        tick();
        check("basic.drained", 64'(out_valid), 64'd0);

        // LSB-first instance
        l_in_valid = 1'b1;
        l_in_data = 8'h11; tick();
        l_in_data = 8'h22; tick();
        l_in_data = 8'h33; tick();
        l_in_data = 8'h44; tick();
        l_in_valid = 1'b0;
        check("lsb.valid", 64'(l_out_valid), 64'd1);
        check("lsb.data", 64'(l_out_data), 64'h4433_2211);
        check("lsb.bytes", 64'(l_out_bytes), 64'd4);

        // Backpressure
        send(8'hDE);
        send(8'hAD);
        send(8'hBE);
        send(8'hEF);
        check_word("bp.first", 32'hDEAD_BEEF, 3'd4);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h01; #1 check("bp.rdy1", 64'(in_ready), 64'd1); tick();
        in_data = 8'h02; #1 check("bp.rdy2", 64'(in_ready), 64'd1); tick();
        in_data = 8'h03; #1 check("bp.rdy3", 64'(in_ready), 64'd1); tick();
        in_data = 8'h04; #1 check("bp.rdy4", 64'(in_ready), 64'd0);
        check("bp.hold_data", 64'(out_data), 64'hDEAD_BEEF);
        tick();
        check("bp.still_blocked", 64'(in_ready), 64'd0);
        check_word("bp.hold", 32'hDEAD_BEEF, 3'd4);
        out_ready = 1'b1;
        #1 check("bp.rdy_release", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_word("bp.second", 32'h0102_0304, 3'd4);
        tick();
        check("bp.drained", 64'(out_valid), 64'd0);

        // Flush of a partial word
        send(8'hAA);
        send(8'hBB);
        flush = 1'b1;
        #1 check("flush.in_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 1'b0;
        check_word("flush.partial", 32'hAABB_0000, 3'd2);

        // Flush together with a byte at cnt 0
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hCC;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_word("flush.with_byte", 32'hCC00_0000, 3'd1);

        // Idle flush: nothing emitted, counter untouched
        flush = 1'b1;
        tick();
        check("idle.valid0", 64'(out_valid), 64'd0);
        tick();
        check("idle.valid1", 64'(out_valid), 64'd0);
        flush = 1'b0;
        send(8'h12);
        send(8'h34);
        send(8'h56);
        send(8'h78);
        check_word("idle.next", 32'h1234_5678, 3'd4);

        // Asynchronous reset with a held word and a partial word in progress
        out_ready = 1'b0;
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        send(8'hA4);
        send(8'h01);
        send(8'h02);
        check("rst2.held", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst2.valid", 64'(out_valid), 64'd0);
        check("rst2.data", 64'(out_data), 64'd0);
        check("rst2.bytes", 64'(out_bytes), 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        check_word("rst2.after", 32'h0102_0304, 3'd4);
        tick();

        // Throughput: 16 back-to-back bytes, one word every 4 cycles
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(8'h10 + i);
            #1 check($sformatf("tp.in_ready%0d", i), 64'(in_ready), 64'd1);
            tick();
            if ((i % 4) == 3) begin
                check_word($sformatf("tp.word%0d", i / 4),
                           {8'(8'h10 + i - 3), 8'(8'h10 + i - 2),
                            8'(8'h10 + i - 1), 8'(8'h10 + i)}, 3'd4);
            end else begin
                check($sformatf("tp.gap%0d", i), 64'(out_valid), 64'd0);
            end
        end
        in_valid = 1'b0;
        tick();
        check("tp.drained", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
- Reassembles a serial stream of 8-bit bytes into full-width words; the inverse of the word-to-byte splitter.
- Sits between byte-oriented sources (UART/serial loaders, byte-wide memory ports) and the 32-bit datapath.
- Uses valid/ready handshakes on both sides, one-word output buffering and a flush for partial words.
- Sustains one byte per cycle while the consumer keeps up.

Parameters:
- BYTES, 4: bytes per output word; legal values are 2 to 8.
- MSB_FIRST, 1: when 1, the first byte received lands in the most significant byte of the word (byte k goes to bits [8*(BYTES-k)-1 -: 8]). When 0, the first byte lands in the least significant byte (byte k goes to bits [8*k+7 -: 8]).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  incoming byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  packer accepts a byte or flush this cycle.
- flush  in  1  request to emit the partial word; a level signal, held until accepted.
- out_data  out  8*BYTES  assembled word.
- out_valid  out  1  out_data and out_bytes are valid.
- out_ready  in  1  consumer accepts the word.
- out_bytes  out  $clog2(BYTES+1)  count of meaningful bytes in out_data, 1 to BYTES.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - acc and cnt clear to 0.
  - out_data = 0, out_valid = 0, out_bytes = 0.
  - Takes effect immediately. A partial word in progress is discarded and no word is emitted.
- Internal state:
  - Accumulator acc (8*BYTES bits) and byte counter cnt (0 to BYTES-1).
  - Output register holding out_data, out_bytes and out_valid.
- Handshake terms:
  - out_free = !out_valid | out_ready.
  - in_ready = out_free | (cnt != BYTES-1 & !flush). in_ready depends combinationally on flush; it does not depend on in_valid.
  - byte_fire = in_valid & in_ready.
  - flush_fire = flush & out_free & (cnt != 0 | in_valid).
- byte_fire without a completing word: in_data is written into acc at slot cnt; cnt increments.
- Word completion (byte_fire with cnt == BYTES-1):
  - Next edge: out_data = the completed word, out_bytes = BYTES, out_valid = 1.
  - acc clears and cnt returns to 0.
  - Latency is 1 cycle from the last byte's handshake to out_valid.
- flush_fire:
  - Any byte accepted in the same cycle is included.
  - The word is emitted with its unused slots zero.
  - out_bytes = cnt (+1 if byte_fire that cycle).
  - acc clears and cnt returns to 0.
- Flush with cnt == 0 and no in_valid: no word is emitted and nothing changes.
- Flush while out_free == 0: not accepted. Bytes may still be accepted while cnt < BYTES-1 … no: while flush is held, in_ready is low unless out_free, so no bytes are accepted until the flush is taken.
- Output register:
  - Holds out_data and out_bytes stable while out_valid & !out_ready.
  - Clears out_valid on out_valid & out_ready, unless a new word loads in the same cycle.
  - A simultaneous drain and load gives back-to-back words with no bubble.
- Backpressure: the accumulator keeps collecting while the output is blocked. in_ready drops only when the next byte would complete a word (cnt == BYTES-1) and out_free == 0.
- Accepted bytes are never lost or reordered. There is no overflow condition.
- cnt wraps only through completion or flush, never by overflow.

Decomposition:
- Package packer_pkg holds:
  - BYTE_W = 8.
  - A function slot_lsb(k, BYTES, MSB_FIRST) returning the LSB position of byte slot k.
  - A typedef for the counter width.
- One natural sub-module, pack_out_stage: a one-entry valid/ready holding register (data + byte count) exposing out_free.
- byte_packer contains the accumulator, the counter and the fire logic.

Test Plan:
- Basic MSB-first word: bytes 0x00, 0x00, 0x00, 0x05 with out_ready=1 -> out_data = 0x00000005 and out_bytes = 4, one cycle after the fourth byte; word round-trips through the splitter to O1..O4 = 00, 00, 00, 05.
- MSB_FIRST=0: bytes 0x11, 0x22, 0x33, 0x44 -> out_data = 0x44332211.
- Backpressure: out_ready=0 after word 0xDEADBEEF, keep streaming 0x01, 0x02, 0x03, 0x04.
  - in_ready drops only when 0x04 is presented.
  - out_data holds 0xDEADBEEF until out_ready.
  - 0x01020304 follows on the next cycle.
- Flush: bytes 0xAA, 0xBB, then flush -> out_data = 0xAABB0000, out_bytes = 2. Separately, flush together with byte 0xCC at cnt=0 -> out_data = 0xCC000000, out_bytes = 1.
- Idle flush and reset: flush with cnt=0 and no in_valid -> no out_valid. rst_n pulsed low after 2 bytes -> outputs 0; bytes 0x01..0x04 afterward -> 0x01020304.
- Throughput: 16 continuous bytes with out_ready=1 -> 4 words on consecutive out_valid windows, one every 4 cycles, with in_ready never low.
